// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the CPU-to-mmu memory bus sequencer
package mem_pkg;

    localparam int MEM_WORD_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } mem_size_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERR,
        ST_RD,
        ST_MERGE,
        ST_WSET,
        ST_WPULSE,
        ST_WHOLD,
        ST_DONE
    } mem_state_t;

    // Reserved size is treated like a misaligned access: rejected before any strobe.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return |addr_lo;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian lane extract/extend for loads and lane merge for stores
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [MEM_WORD_W-1:0] word,
    input  logic [1:0]            addr_lo,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [MEM_WORD_W-1:0] wdata,
    output logic [MEM_WORD_W-1:0] load_data,
    output logic [MEM_WORD_W-1:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = word[{addr_lo, 3'b000} +: 8];
        half_sel   = addr_lo[1] ? word[31:16] : word[15:0];
        load_data  = word;
        store_word = wdata;
        case (mem_size_t'(size))
            SZ_BYTE: begin
                load_data  = {{24{sign_ext & byte_sel[7]}}, byte_sel};
                store_word = word;
                store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data  = {{16{sign_ext & half_sel[15]}}, half_sel};
                store_word = addr_lo[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - one-request-at-a-time sequencer producing registered N_OE/N_WE strobes
module mem_bus_ctrl
    import mem_pkg::*;
#(
    parameter int RD_WAIT  = 1,
    parameter int WE_PULSE = 1
) (
    input  logic        CLK,
    input  logic        N_RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [31:0] REQ_ADDR,
    input  logic        REQ_WE,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_SIGNED,
    input  logic [31:0] REQ_WDATA,
    output logic        RESP_VALID,
    output logic [31:0] RESP_RDATA,
    output logic        RESP_ERR,
    output logic [31:0] MEM_ADDR,
    output logic        MEM_N_OE,
    output logic        MEM_N_WE,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA
);

    localparam logic [7:0] RD_LOAD = 8'(RD_WAIT - 1);
    localparam logic [7:0] WE_LOAD = 8'(WE_PULSE - 1);

    mem_state_t  state;
    logic [7:0]  cnt;
    logic [1:0]  r_addr_lo;
    mem_size_t   r_size;
    logic        r_signed;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [31:0] load_data;
    logic [31:0] store_word;

    mem_lane_align u_align (
        .word       (MEM_RDATA),
        .addr_lo    (r_addr_lo),
        .size       (r_size),
        .sign_ext   (r_signed),
        .wdata      (r_wdata),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Every output is a flop updated on the transition into the state that owns it,
    // so strobes never pass through decode logic.
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state      <= ST_IDLE;
            cnt        <= 8'd0;
            r_addr_lo  <= 2'b00;
            r_size     <= SZ_BYTE;
            r_signed   <= 1'b0;
            r_we       <= 1'b0;
            r_wdata    <= 32'd0;
            REQ_READY  <= 1'b1;
            RESP_VALID <= 1'b0;
            RESP_RDATA <= 32'd0;
            RESP_ERR   <= 1'b0;
            MEM_ADDR   <= 32'd0;
            MEM_N_OE   <= 1'b1;
            MEM_N_WE   <= 1'b1;
            MEM_WDATA  <= 32'd0;
        end else begin
            RESP_VALID <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        REQ_READY <= 1'b0;
                        r_addr_lo <= REQ_ADDR[1:0];
                        r_size    <= mem_size_t'(REQ_SIZE);
                        r_signed  <= REQ_SIGNED;
                        r_we      <= REQ_WE;
                        r_wdata   <= REQ_WDATA;
                        if (is_misaligned(mem_size_t'(REQ_SIZE), REQ_ADDR[1:0])) begin
                            state <= ST_ERR;
                        end else begin
                            MEM_ADDR <= {REQ_ADDR[31:2], 2'b00};
                            if (!REQ_WE || mem_size_t'(REQ_SIZE) != SZ_WORD) begin
                                state    <= ST_RD;
                                MEM_N_OE <= 1'b0;
                                cnt      <= RD_LOAD;
                            end else begin
                                state     <= ST_WSET;
                                MEM_WDATA <= REQ_WDATA;
                            end
                        end
                    end
                end
                ST_ERR: begin
                    state      <= ST_DONE;
                    RESP_VALID <= 1'b1;
                    RESP_ERR   <= 1'b1;
                    RESP_RDATA <= 32'd0;
                end
                ST_RD: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        MEM_N_OE <= 1'b1;
                        if (r_we) begin
                            MEM_WDATA <= store_word;
                            state     <= ST_MERGE;
                        end else begin
                            RESP_RDATA <= load_data;
                            RESP_VALID <= 1'b1;
                            RESP_ERR   <= 1'b0;
                            state      <= ST_DONE;
                        end
                    end
                end
                ST_MERGE: begin
                    state <= ST_WSET;
                end
                ST_WSET: begin
                    MEM_N_WE <= 1'b0;
                    cnt      <= WE_LOAD;
                    state    <= ST_WPULSE;
                end
                ST_WPULSE: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        MEM_N_WE <= 1'b1;
                        state    <= ST_WHOLD;
                    end
                end
                ST_WHOLD: begin
                    state      <= ST_DONE;
                    RESP_VALID <= 1'b1;
                    RESP_ERR   <= 1'b0;
                    RESP_RDATA <= 32'd0;
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    REQ_READY  <= 1'b1;
                    RESP_ERR   <= 1'b0;
                    RESP_RDATA <= 32'd0;
                end
                default: begin
                    state     <= ST_IDLE;
                    REQ_READY <= 1'b1;
                    MEM_N_OE  <= 1'b1;
                    MEM_N_WE  <= 1'b1;
                end
            endcase
        end
    end

endmodule
